rx_peak_detector: RTL and testbench

//  Sits directly downstream of rx_top_level. Consumes its 16 signed 41-bit correlation results, one set per input sample.

---
 rtl/rx_peak_detector.sv | 161 ++++++++++++++++
 tb/tb_rx_peak_detector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_peak_detector.sv
// Serial peak search over 16 correlation codes and a window of samples.
// Reports the largest magnitude, its code and its sample index per window.
module rx_peak_detector #(
  parameter int WIDTH  = 41,
  parameter int WINDOW = 1024,
  parameter int WIN_W  = 10
) (
  input  logic               crx_clk,
  input  logic               rrx_rst,
  input  logic               erx_en,
  input  logic               icorr_valid,
  input  logic [WIDTH-1:0]   icorr_result_0,
  input  logic [WIDTH-1:0]   icorr_result_1,
  input  logic [WIDTH-1:0]   icorr_result_2,
  input  logic [WIDTH-1:0]   icorr_result_3,
  input  logic [WIDTH-1:0]   icorr_result_4,
  input  logic [WIDTH-1:0]   icorr_result_5,
  input  logic [WIDTH-1:0]   icorr_result_6,
  input  logic [WIDTH-1:0]   icorr_result_7,
  input  logic [WIDTH-1:0]   icorr_result_8,
  input  logic [WIDTH-1:0]   icorr_result_9,
  input  logic [WIDTH-1:0]   icorr_result_10,
  input  logic [WIDTH-1:0]   icorr_result_11,
  input  logic [WIDTH-1:0]   icorr_result_12,
  input  logic [WIDTH-1:0]   icorr_result_13,
  input  logic [WIDTH-1:0]   icorr_result_14,
  input  logic [WIDTH-1:0]   icorr_result_15,
  input  logic [WIDTH-2:0]   ithreshold,
  output logic               opeak_valid,
  output logic               opeak_found,
  output logic [WIDTH-2:0]   opeak_value,
  output logic [3:0]         opeak_code,
  output logic [WIN_W-1:0]   opeak_index,
  output logic               obusy,
  output logic               ooverrun
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIDTH-2:0] ONE  = {{(WIDTH-2){1'b0}}, 1'b1};

  state_t             state;
  logic [WIDTH-1:0]   results [16];
  logic [WIDTH-1:0]   snap    [16];
  logic [3:0]         chan;
  logic [WIN_W-1:0]   samp_cnt;
  logic [WIDTH-2:0]   best_mag;
  logic [3:0]         best_code;
  logic [WIN_W-1:0]   best_idx;
  logic               found;

  logic [WIDTH-1:0]   cur;
  logic [WIDTH-2:0]   mag;
  logic               upd;

  assign results = '{
    icorr_result_0,  icorr_result_1,
    icorr_result_2,  icorr_result_3,
    icorr_result_4,  icorr_result_5,
    icorr_result_6,  icorr_result_7,
    icorr_result_8,  icorr_result_9,
    icorr_result_10, icorr_result_11,
    icorr_result_12, icorr_result_13,
    icorr_result_14, icorr_result_15
  };

  assign obusy = (state != IDLE);

  // Magnitude of the channel under scan; most negative value saturates.
  always_comb begin
    cur = snap[chan];
    mag = cur[WIDTH-2:0];
    if (cur[WIDTH-1]) begin
      if (cur[WIDTH-2:0] == '0) begin
        mag = '1;
      end else begin
        mag = ~cur[WIDTH-2:0] + ONE;
      end
    end
    upd = (mag >= ithreshold) &&
          (!found || (mag > best_mag));
  end

  // Control FSM, best-so-far tracking and registered report outputs.
  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      state       <= IDLE;
      chan        <= '0;
      samp_cnt    <= '0;
      best_mag    <= '0;
      best_code   <= '0;
      best_idx    <= '0;
      found       <= 1'b0;
      opeak_valid <= 1'b0;
      opeak_found <= 1'b0;
      opeak_value <= '0;
      opeak_code  <= '0;
      opeak_index <= '0;
      ooverrun    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        snap[i] <= '0;
      end
    end else begin
      opeak_valid <= 1'b0;
      if (erx_en) begin
        if (icorr_valid && state != IDLE) begin
          ooverrun <= 1'b1;
        end
        unique case (state)
          IDLE: begin
            if (icorr_valid) begin
              for (int i = 0; i < 16; i++) begin
                snap[i] <= results[i];
              end
              chan  <= '0;
              state <= SCAN;
            end
          end
          SCAN: begin
            if (upd) begin
              best_mag  <= mag;
              best_code <= chan;
              best_idx  <= samp_cnt;
              found     <= 1'b1;
            end
            if (chan == 4'd15) begin
              if (samp_cnt == LAST) begin
                state <= REPORT;
              end else begin
                samp_cnt <= samp_cnt + WIN_W'(1);
                state    <= IDLE;
              end
            end else begin
              chan <= chan + 4'd1;
            end
          end
          REPORT: begin
            opeak_valid <= 1'b1;
            opeak_found <= found;
            opeak_value <= found ? best_mag  : '0;
            opeak_code  <= found ? best_code : '0;
            opeak_index <= found ? best_idx  : '0;
            best_mag    <= '0;
            best_code   <= '0;
            best_idx    <= '0;
            found       <= 1'b0;
            samp_cnt    <= '0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_peak_detector.sv
// Bench for rx_peak_detector: directed windows with literal results,
// plus random strobes checked each cycle against a window-level model.
module tb_rx_peak_detector;

  localparam int W = 41;
  localparam int WIN = 8;
  localparam longint THR = 1000;
  localparam longint MAXM = 64'h0000_00FF_FFFF_FFFF;

  logic              crx_clk = 1'b0;
  logic              rrx_rst = 1'b1;
  logic              erx_en = 1'b1;
  logic              icorr_valid = 1'b0;
  logic signed [W-1:0] res [16];
  logic [W-2:0]      ithreshold = 40'(THR);
  logic              opeak_valid;
  logic              opeak_found;
  logic [W-2:0]      opeak_value;
  logic [3:0]        opeak_code;
  logic [2:0]        opeak_index;
  logic              obusy;
  logic              ooverrun;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 crx_clk = ~crx_clk;

  rx_peak_detector #(.WIDTH(W), .WINDOW(WIN), .WIN_W(3)) dut (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst),
    .erx_en(erx_en), .icorr_valid(icorr_valid),
    .icorr_result_0(res[0]),   .icorr_result_1(res[1]),
    .icorr_result_2(res[2]),   .icorr_result_3(res[3]),
    .icorr_result_4(res[4]),   .icorr_result_5(res[5]),
    .icorr_result_6(res[6]),   .icorr_result_7(res[7]),
    .icorr_result_8(res[8]),   .icorr_result_9(res[9]),
    .icorr_result_10(res[10]), .icorr_result_11(res[11]),
    .icorr_result_12(res[12]), .icorr_result_13(res[13]),
    .icorr_result_14(res[14]), .icorr_result_15(res[15]),
    .ithreshold(ithreshold),
    .opeak_valid(opeak_valid), .opeak_found(opeak_found),
    .opeak_value(opeak_value), .opeak_code(opeak_code),
    .opeak_index(opeak_index), .obusy(obusy),
    .ooverrun(ooverrun)
  );

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     t = 0;
  int     next_ok = 0;
  int     last_acc = -1000;
  int     report_at = -1;
  int     nsamp = 0;
  bit     w_found = 0;
  longint w_best = 0;
  int     w_code = 0;
  int     w_idx = 0;
  bit     p_found = 0;
  longint p_best = 0;
  int     p_code = 0;
  int     p_idx = 0;
  bit     e_valid = 0;
  bit     e_found = 0;
  longint e_value = 0;
  int     e_code = 0;
  int     e_idx = 0;
  bit     e_busy = 0;
  bit     e_ovr = 0;

  initial forever begin
    @(posedge crx_clk);
    t++;
    if (!rrx_rst) begin
      next_ok = 0; last_acc = -1000; report_at = -1;
      nsamp = 0; w_found = 0; w_best = 0;
      w_code = 0; w_idx = 0;
      e_valid = 0; e_found = 0; e_value = 0;
      e_code = 0; e_idx = 0; e_busy = 0; e_ovr = 0;
    end else begin
      if (t == report_at) begin
        e_valid = 1; e_found = p_found;
        e_value = p_best; e_code = p_code;
        e_idx = p_idx; report_at = -1;
      end else begin
        e_valid = 0;
      end
      if (icorr_valid && erx_en) begin
        if (t < next_ok) begin
          e_ovr = 1;
        end else begin
          for (int k = 0; k < 16; k++) begin
            longint v;
            longint m;
            v = res[k];
            m = (v < 0) ? -v : v;
            if (m > MAXM) m = MAXM;
            if (m >= THR && (!w_found || m > w_best)) begin
              w_found = 1; w_best = m;
              w_code = k; w_idx = nsamp;
            end
          end
          last_acc = t;
          nsamp++;
          if (nsamp == WIN) begin
            report_at = t + 17;
            next_ok = t + 18;
            p_found = w_found; p_best = w_best;
            p_code = w_code; p_idx = w_idx;
            w_found = 0; w_best = 0;
            w_code = 0; w_idx = 0; nsamp = 0;
          end else begin
            next_ok = t + 17;
          end
        end
      end
      e_busy = (t >= last_acc) && (t < next_ok - 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge crx_clk);
    if (rrx_rst && cmp_on) begin
      chk("valid", opeak_valid, e_valid);
      chk("busy", obusy, e_busy);
      chk("overrun", ooverrun, e_ovr);
      chk("found", opeak_found, e_found);
      chk("value", opeak_value, e_value);
      chk("code", opeak_code, e_code);
      chk("index", opeak_index, e_idx);
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill(longint v);
    for (int k = 0; k < 16; k++) res[k] = 41'(v);
  endtask

  task automatic pulse();
    icorr_valid = 1'b1;
    @(negedge crx_clk);
    icorr_valid = 1'b0;
  endtask

  task automatic window(int kind, bit f, longint v, int c, int ix);
    int lat;
    for (int s = 0; s < WIN; s++) begin
      case (kind)
        1: begin fill(100); if (s == 3) res[7] = 41'sd5000; end
        2: begin fill(0); if (s == 0) res[0] = {1'b1, 40'd0}; end
        3: begin
          fill(0);
          if (s == 1) begin res[2] = 41'sd3000; res[9] = 41'sd3000; end
          if (s == 5) res[4] = 41'sd3000;
        end
        4: fill(999);
        default: begin fill(100); if (s == 2) res[3] = 41'sd2000; end
      endcase
      pulse();
      if (kind == 5 && s == 0) begin
        repeat (4) @(negedge crx_clk);
        res[1] = 41'sd9000;
        pulse();
        chk("overrun_set", ooverrun, 1);
        repeat (11) @(negedge crx_clk);
      end else if (s < WIN - 1) begin
        repeat (16) @(negedge crx_clk);
      end
    end
    lat = 0;
    while (!opeak_valid && lat < 40) begin
      @(negedge crx_clk);
      lat++;
    end
    chk($sformatf("latency_k%0d", kind), lat, 17);
    chk($sformatf("found_k%0d", kind), opeak_found, f);
    chk($sformatf("value_k%0d", kind), opeak_value, v);
    chk($sformatf("code_k%0d", kind), opeak_code, c);
    chk($sformatf("index_k%0d", kind), opeak_index, ix);
    repeat (2) @(negedge crx_clk);
  endtask

  initial begin
    fill(0);
    #1 rrx_rst = 1'b0;
    repeat (3) @(negedge crx_clk);
    chk("rst_valid", opeak_valid, 0);
    chk("rst_busy", obusy, 0);
    chk("rst_overrun", ooverrun, 0);
    chk("rst_value", opeak_value, 0);
    #2 rrx_rst = 1'b1;
    @(negedge crx_clk);
    cmp_on = 1'b1;

    window(1, 1, 5000, 7, 3);
    window(2, 1, MAXM, 0, 0);
    window(3, 1, 3000, 2, 1);
    window(4, 0, 0, 0, 0);
    window(5, 1, 2000, 3, 2);

    fill(100);
    res[6] = 41'sd7000;
    pulse();
    repeat (6) @(negedge crx_clk);
    #2 rrx_rst = 1'b0;
    #1;
    chk("midrst_busy", obusy, 0);
    chk("midrst_found", opeak_found, 0);
    chk("midrst_value", opeak_value, 0);
    chk("midrst_overrun", ooverrun, 0);
    @(negedge crx_clk);
    #2 rrx_rst = 1'b1;
    @(negedge crx_clk);
    window(1, 1, 5000, 7, 3);

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 16; k++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) begin
          res[k] = 41'($urandom_range(0, 2000));
          if ($urandom_range(0, 1) == 1) res[k] = -res[k];
        end else if (r < 17) begin
          res[k] = '0;
        end else if (r < 19) begin
          res[k] = 41'({$urandom(), $urandom()});
        end else begin
          res[k] = {1'b1, 40'd0};
        end
      end
      pulse();
      repeat ($urandom_range(0, 19)) @(negedge crx_clk);
    end
    repeat (40) @(negedge crx_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
